// File: rtl/mram_pkg.sv
// Shared MRAM read/write types, widths and strobe constants.
// MRAM_READ_PARITY_EN widens the read frame by one even-parity bit.
package mram_pkg;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 16;
  localparam int CNT_W  = 5;

`ifdef MRAM_READ_PARITY_EN
  localparam int FRAME_W = DATA_W + 1;
`else
  localparam int FRAME_W = DATA_W;
`endif

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_SHIFT  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // {chip_en, write_en, out_en, lower_byte_en, upper_byte_en}
  localparam logic [4:0] STROBE_IDLE = 5'b11111;
  localparam logic [4:0] STROBE_READ = 5'b01000;

  function automatic logic [FRAME_W-1:0] frame_word(
    input logic [DATA_W-1:0] d
  );
`ifdef MRAM_READ_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shift register, LSB leaves first.
// Load has priority over shift.
module piso_shift_reg #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift_en,
  input  logic [W-1:0] din,
  output logic         sout
);

  logic [W-1:0] sr;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '0;
    end else if (load) begin
      sr <= din;
    end else if (shift_en) begin
      sr <= {1'b0, sr[W-1:1]};
    end
  end

  assign sout = sr[0];

endmodule

// File: rtl/mram_read_serializer.sv
// Reads one MRAM word and streams it out serially, LSB first.
// Define MRAM_READ_PARITY_EN to append an even-parity bit.
module mram_read_serializer
  import mram_pkg::*;
#(
  parameter int unsigned READ_WAIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] mram_data_in,
  output logic [ADDR_W-1:0] addr_out,
  output logic              chip_en,
  output logic              write_en,
  output logic              out_en,
  output logic              lower_byte_en,
  output logic              upper_byte_en,
  output logic              data_out,
  output logic              data_valid,
  output logic              busy,
  output logic              done
);

  localparam logic [CNT_W-1:0] ACC_LAST =
    CNT_W'(READ_WAIT - 1);
  localparam logic [CNT_W-1:0] SHIFT_LAST =
    CNT_W'(FRAME_W - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [4:0]       strobe;
  logic             load;
  logic             shift_en;
  logic             ser;

  assign load     = (state == S_ACCESS) && (cnt == ACC_LAST);
  assign shift_en = (state == S_SHIFT);

  piso_shift_reg #(
    .W(FRAME_W)
  ) u_piso (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .shift_en(shift_en),
    .din     (frame_word(mram_data_in)),
    .sout    (ser)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      addr_out   <= '0;
      strobe     <= STROBE_IDLE;
      data_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            addr_out <= addr_in;
            cnt      <= '0;
            strobe   <= STROBE_READ;
            busy     <= 1'b1;
            state    <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (cnt == ACC_LAST) begin
            cnt        <= '0;
            strobe     <= STROBE_IDLE;
            data_valid <= 1'b1;
            state      <= S_SHIFT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_SHIFT: begin
          if (cnt == SHIFT_LAST) begin
            cnt        <= '0;
            data_valid <= 1'b0;
            done       <= 1'b1;
            state      <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign {chip_en, write_en, out_en,
          lower_byte_en, upper_byte_en} = strobe;

  // Gate keeps the line low outside a frame.
  assign data_out = data_valid & ser;

endmodule

// File: tb/tb_mram_read_serializer.sv
// Randomized bench: two instances (READ_WAIT 3 and 1) against a
// transaction-timeline reference model.
module tb_mram_read_serializer;
  import mram_pkg::*;

  localparam int F = FRAME_W;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start [2];
  logic [19:0] addr_in [2];
  logic [15:0] din [2];
  logic [19:0] addr_o [2];
  logic        ce [2], we [2], oe [2], lb [2], ub [2];
  logic        dout [2], dv [2], bsy [2], dn [2];

  int n_chk = 0;
  int n_err = 0;

  bit          act [2];
  int          t [2];
  logic [15:0] cap [2];
  logic [19:0] maddr [2];

  always #5 clk = ~clk;

  mram_read_serializer #(.READ_WAIT(3)) u0 (
    .clk(clk), .rst(rst), .start(start[0]),
    .addr_in(addr_in[0]), .mram_data_in(din[0]),
    .addr_out(addr_o[0]), .chip_en(ce[0]), .write_en(we[0]),
    .out_en(oe[0]), .lower_byte_en(lb[0]),
    .upper_byte_en(ub[0]), .data_out(dout[0]),
    .data_valid(dv[0]), .busy(bsy[0]), .done(dn[0])
  );

  mram_read_serializer #(.READ_WAIT(1)) u1 (
    .clk(clk), .rst(rst), .start(start[1]),
    .addr_in(addr_in[1]), .mram_data_in(din[1]),
    .addr_out(addr_o[1]), .chip_en(ce[1]), .write_en(we[1]),
    .out_en(oe[1]), .lower_byte_en(lb[1]),
    .upper_byte_en(ub[1]), .data_out(dout[1]),
    .data_valid(dv[1]), .busy(bsy[1]), .done(dn[1])
  );

  function automatic int rw(input int l);
    return (l == 0) ? 3 : 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t",
               tag, got, exp, $time);
    end
  endtask

  // Reference: a transaction is a timeline of t cycles since its accept.
  always @(posedge clk) begin
    for (int l = 0; l < 2; l++) begin
      bit idle;
      idle = !act[l];
      if (rst) begin
        act[l]   = 1'b0;
        maddr[l] = '0;
      end else begin
        if (act[l]) begin
          t[l]++;
          if (t[l] == rw(l)) cap[l] = din[l];
          if (t[l] > rw(l) + F) act[l] = 1'b0;
        end
        if (idle && start[l]) begin
          act[l]   = 1'b1;
          t[l]     = 0;
          maddr[l] = addr_in[l];
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int l = 0; l < 2; l++) begin
      logic [4:0] es;
      logic ev, eo, eb, ed;
      int i;
      es = 5'b11111; ev = 0; eo = 0; eb = 0; ed = 0;
      if (act[l]) begin
        eb = 1;
        if (t[l] < rw(l)) begin
          es = 5'b01000;
        end else if (t[l] < rw(l) + F) begin
          i  = t[l] - rw(l);
          ev = 1;
          eo = (i < 16) ? cap[l][i] : ^cap[l];
        end else begin
          ed = 1;
        end
      end
      chk($sformatf("strobes%0d", l),
          {27'd0, ce[l], we[l], oe[l], lb[l], ub[l]}, {27'd0, es});
      chk($sformatf("data_out%0d", l), {31'd0, dout[l]}, {31'd0, eo});
      chk($sformatf("valid%0d", l), {31'd0, dv[l]}, {31'd0, ev});
      chk($sformatf("busy%0d", l), {31'd0, bsy[l]}, {31'd0, eb});
      chk($sformatf("done%0d", l), {31'd0, dn[l]}, {31'd0, ed});
      chk($sformatf("addr%0d", l), {12'd0, addr_o[l]},
          {12'd0, maddr[l]});
    end
  end

  task automatic go0(input logic [19:0] a, input logic [15:0] d);
    addr_in[0] = a;
    din[0]     = d;
    start[0]   = 1'b1;
    @(negedge clk);
    start[0]   = 1'b0;
  endtask

  initial begin
    for (int l = 0; l < 2; l++) begin
      start[l] = 0; addr_in[l] = '0; din[l] = '0;
      act[l] = 0; t[l] = 0; cap[l] = '0; maddr[l] = '0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Known frame, plus a start pulse in the 5th SHIFT cycle.
    go0(20'hABCDE, 16'hA5C3);
    repeat (6) @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (20) @(negedge clk);

    // Reset during the 2nd ACCESS cycle.
    go0(20'h12345, 16'h0F0F);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    go0(20'h00001, 16'h0001);
    repeat (25) @(negedge clk);
    go0(20'h00002, 16'h0003);
    repeat (25) @(negedge clk);

    // Back-to-back reads on the READ_WAIT=1 instance.
    start[1]   = 1'b1;
    addr_in[1] = 20'h55555;
    din[1]     = 16'hBEEF;
    repeat (60) @(negedge clk);
    start[1]   = 1'b0;
    repeat (5) @(negedge clk);

    for (int c = 0; c < 3000; c++) begin
      for (int l = 0; l < 2; l++) begin
        start[l]   = ($urandom % 6) == 0;
        addr_in[l] = 20'($urandom);
        din[l]     = 16'($urandom);
      end
      rst = ($urandom % 300) == 0;
      @(negedge clk);
    end
    rst = 1'b0;
    start[0] = 1'b0;
    start[1] = 1'b0;
    repeat (30) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
